tx_100g: RTL and testbench

- 100G transmit MAC datapath that reads packet words from the TX buffer FIFO and drives the 256-bit XGMII-style transmit interface (32 bytes, 32 ctrl bits; byte i = data[8i+7:8i], ctrl[i]).
- Inserts start/preamble/SFD, terminate, idle and the inter-packet gap.
- Sends remote-fault ordered sets while the link is down.
- Emits exactly the character set and byte lanes that rx_100G parses on the receive side.

---
 rtl/tx_100g_pkg.sv | 36 +++
 rtl/xgmii_term_mask.sv | 25 ++
 rtl/tx_100g.sv | 150 +++++++++++++++
 tb/tb_tx_100g.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_100g_pkg.sv
// Shared XGMII character set, fixed lane patterns and transmit state encoding
// for the 100G transmit MAC.
package tx_100g_pkg;

  localparam logic [7:0] XG_IDLE     = 8'h07;
  localparam logic [7:0] XG_START    = 8'hFB;
  localparam logic [7:0] XG_PREAMBLE = 8'h55;
  localparam logic [7:0] XG_SFD      = 8'hD5;
  localparam logic [7:0] XG_TERM     = 8'hFD;
  localparam logic [7:0] XG_ERROR    = 8'hFE;
  localparam logic [7:0] XG_SEQ      = 8'h9C;

  // Lane byte 0 sits in bits [7:0]; remote fault is 9C,00,00,02,00,00,00,00 on the wire.
  localparam logic [63:0]  RF_LANE       = {32'h0000_0000, 8'h02, 8'h00, 8'h00, XG_SEQ};
  localparam logic [255:0] RF_WORD       = {4{RF_LANE}};
  localparam logic [31:0]  RF_CTRL       = 32'h0101_0101;
  localparam logic [63:0]  PREAMBLE_LANE = {XG_SFD, {6{XG_PREAMBLE}}, XG_START};
  localparam logic [255:0] IDLE_WORD     = {32{XG_IDLE}};
  localparam logic [255:0] ABORT_WORD    = {{30{XG_IDLE}}, XG_TERM, XG_ERROR};

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_DATA    = 6'b000010,
    ST_TAIL    = 6'b000100,
    ST_IPG     = 6'b001000,
    ST_DISCARD = 6'b010000,
    ST_FAULT   = 6'b100000
  } tx_state_e;

  function automatic logic [255:0] expand_ctrl(input logic [31:0] m);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

endpackage

// File: rtl/xgmii_term_mask.sv
// Terminate fill for a word ending at byte p: FD at p, 07 above it, zero below,
// with the matching ctrl mask.
module xgmii_term_mask
  import tx_100g_pkg::*;
(
  input  logic [4:0]   pos,
  output logic [255:0] fill,
  output logic [31:0]  ctrl_mask
);

  always_comb begin
    fill      = '0;
    ctrl_mask = '0;
    for (int i = 0; i < 32; i++) begin
      if (5'(i) == pos) begin
        fill[8*i +: 8] = XG_TERM;
        ctrl_mask[i]   = 1'b1;
      end else if (5'(i) > pos) begin
        fill[8*i +: 8] = XG_IDLE;
        ctrl_mask[i]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_100g.sv
// 100G transmit MAC: frames FIFO words onto a 256-bit XGMII interface with
// preamble, terminate, inter-packet gap, abort and remote-fault signalling.
module tx_100g
  import tx_100g_pkg::*;
#(
  parameter int IPG_BYTES = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         link_ok,
  input  logic [255:0] in_data,
  input  logic         in_sof,
  input  logic         in_eof,
  input  logic [5:0]   in_nbytes,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [255:0] tx_data,
  output logic [31:0]  tx_ctrl,
  output logic         frame_done,
  output logic         underrun_err,
  output logic         proto_err
);

  localparam logic [5:0] IPG_W = 6'(IPG_BYTES);

  tx_state_e    state;
  tx_state_e    frame_next;
  logic [63:0]  carry;
  logic [4:0]   tail_pos;
  logic [5:0]   n_eff;
  logic [4:0]   term_pos;
  logic [255:0] term_fill;
  logic [255:0] term_bytes;
  logic [31:0]  term_ctrl;
  logic [255:0] base_word;
  logic [255:0] tail_word;
  logic [255:0] frame_word;
  logic [31:0]  frame_ctrl;
  logic         frame_term;
  logic         accept;
  logic         is_start;

  assign in_ready = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_DISCARD);
  assign accept   = in_valid & in_ready;
  assign is_start = (state == ST_IDLE);
  assign n_eff    = (in_nbytes == 6'd0 || in_nbytes > 6'd32) ? 6'd32 : in_nbytes;

  // 5-bit wrap is intentional: TAIL position is n-24 (n=32 wraps to 8), EOF position is 8+n for n<=23.
  assign term_pos = (state == ST_TAIL) ? tail_pos : n_eff[4:0] + 5'd8;

  xgmii_term_mask u_term (
    .pos       (term_pos),
    .fill      (term_fill),
    .ctrl_mask (term_ctrl)
  );

  assign term_bytes = expand_ctrl(term_ctrl);
  assign base_word  = {in_data[191:0], is_start ? PREAMBLE_LANE : carry};
  assign tail_word  = ({192'd0, carry} & ~term_bytes) | term_fill;

  always_comb begin
    frame_word = base_word;
    frame_ctrl = {31'd0, is_start};
    frame_term = 1'b0;
    frame_next = ST_DATA;
    if (in_eof) begin
      if (n_eff <= 6'd23) begin
        frame_word = (base_word & ~term_bytes) | term_fill;
        frame_ctrl = term_ctrl | {31'd0, is_start};
        frame_term = 1'b1;
        frame_next = ((6'd23 - n_eff) < IPG_W) ? ST_IPG : ST_IDLE;
      end else begin
        frame_next = ST_TAIL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_FAULT;
      carry        <= '0;
      tail_pos     <= '0;
      tx_data      <= IDLE_WORD;
      tx_ctrl      <= '1;
      frame_done   <= 1'b0;
      underrun_err <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      underrun_err <= 1'b0;
      proto_err    <= 1'b0;
      tx_data      <= IDLE_WORD;
      tx_ctrl      <= '1;
      case (state)
        ST_IDLE: begin
          if (!link_ok) begin
            state <= ST_FAULT;
          end else if (accept && in_sof) begin
            tx_data    <= frame_word;
            tx_ctrl    <= frame_ctrl;
            frame_done <= frame_term;
            carry      <= in_data[255:192];
            tail_pos   <= n_eff[4:0] - 5'd24;
            state      <= frame_next;
          end else begin
            proto_err <= accept;
          end
        end
        ST_DATA: begin
          if (!link_ok || !in_valid) begin
            tx_data      <= ABORT_WORD;
            underrun_err <= 1'b1;
            carry        <= '0;
            state        <= link_ok ? ST_DISCARD : ST_FAULT;
          end else begin
            tx_data    <= frame_word;
            tx_ctrl    <= frame_ctrl;
            frame_done <= frame_term;
            carry      <= in_data[255:192];
            tail_pos   <= n_eff[4:0] - 5'd24;
            state      <= frame_next;
          end
        end
        ST_TAIL: begin
          tx_data    <= tail_word;
          tx_ctrl    <= term_ctrl;
          frame_done <= 1'b1;
          carry      <= '0;
          state      <= ST_IDLE;
        end
        ST_IPG: begin
          state <= link_ok ? ST_IDLE : ST_FAULT;
        end
        ST_DISCARD: begin
          if (accept && in_eof) state <= ST_IDLE;
        end
        ST_FAULT: begin
          if (link_ok) begin
            state <= ST_IDLE;
          end else begin
            tx_data <= RF_WORD;
            tx_ctrl <= RF_CTRL;
          end
        end
        default: state <= ST_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_100g.sv
// Scoreboard bench for tx_100g: a byte-stream reference model predicts each output
// word, a monitor compares it one clock after the stimulus.
module tb_tx_100g;

  localparam int IPG = 12;
  localparam logic [255:0] IDLE_W  = {32{8'h07}};
  localparam logic [255:0] RF_W    = {4{64'h00000000_0200009C}};
  localparam logic [255:0] ABORT_W = {{30{8'h07}}, 8'hFD, 8'hFE};

  logic         clk = 1'b0;
  logic         reset, link_ok, in_sof, in_eof, in_valid, in_ready;
  logic         frame_done, underrun_err, proto_err;
  logic [255:0] in_data, tx_data;
  logic [5:0]   in_nbytes;
  logic [31:0]  tx_ctrl;

  tx_100g #(.IPG_BYTES(IPG)) dut (
    .clk          (clk),
    .reset        (reset),
    .link_ok      (link_ok),
    .in_data      (in_data),
    .in_sof       (in_sof),
    .in_eof       (in_eof),
    .in_nbytes    (in_nbytes),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .tx_data      (tx_data),
    .tx_ctrl      (tx_ctrl),
    .frame_done   (frame_done),
    .underrun_err (underrun_err),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  c;
    logic         fd;
    logic         ue;
    logic         pe;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  // Reference model: the frame is a queue of {ctrl,byte} wire characters drained 32 per clock.
  bit         m_fault, m_in_frame, m_discard, m_gap;
  logic [8:0] m_wire[$];

  function automatic bit m_ready();
    return !m_fault && !m_gap && !(m_wire.size() > 0 && !m_in_frame);
  endfunction

  task automatic m_reset();
    m_fault = 1; m_in_frame = 0; m_discard = 0; m_gap = 0;
    m_wire.delete();
  endtask

  task automatic m_emit();
    int fd_pos;
    logic [8:0] b;
    fd_pos = -1;
    for (int i = 0; i < 32; i++) begin
      if (m_wire.size() > 0) b = m_wire.pop_front();
      else b = {1'b1, 8'h07};
      cur.d[8*i +: 8] = b[7:0];
      cur.c[i] = b[8];
      if (b == {1'b1, 8'hFD}) fd_pos = i;
    end
    if (fd_pos >= 0) begin
      cur.fd = 1'b1;
      if (31 - fd_pos < IPG) m_gap = 1;
    end
  endtask

  task automatic m_accept(input logic [255:0] d, input bit e, input logic [5:0] nb);
    int n;
    n = 32;
    if (e) n = (nb == 0 || nb > 32) ? 32 : int'(nb);
    for (int i = 0; i < n; i++) m_wire.push_back({1'b0, d[8*i +: 8]});
    if (e) begin
      m_wire.push_back({1'b1, 8'hFD});
      m_in_frame = 0;
    end
    m_emit();
  endtask

  task automatic m_step(input bit lk, v, s, e, input logic [5:0] nb, input logic [255:0] d);
    cur = '{d: IDLE_W, c: 32'hFFFFFFFF, fd: 1'b0, ue: 1'b0, pe: 1'b0};
    if (m_fault) begin
      if (lk) m_fault = 0;
      else begin cur.d = RF_W; cur.c = 32'h01010101; end
    end else if (m_wire.size() > 0 && !m_in_frame) begin
      m_emit();
    end else if (m_gap) begin
      m_gap = 0;
      if (!lk) m_fault = 1;
    end else if (m_discard) begin
      if (v && e) m_discard = 0;
    end else if (m_in_frame) begin
      if (!lk || !v) begin
        cur.d = ABORT_W; cur.ue = 1'b1;
        m_wire.delete(); m_in_frame = 0;
        if (lk) m_discard = 1; else m_fault = 1;
      end else begin
        m_accept(d, e, nb);
      end
    end else if (!lk) begin
      m_fault = 1;
    end else if (v && s) begin
      m_wire.push_back({1'b1, 8'hFB});
      for (int i = 0; i < 6; i++) m_wire.push_back({1'b0, 8'h55});
      m_wire.push_back({1'b0, 8'hD5});
      m_in_frame = 1;
      m_accept(d, e, nb);
    end else if (v) begin
      cur.pe = 1'b1;
    end
    exp_q.push_back(cur);
  endtask

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic drive_now(input bit lk, v, s, e, input logic [5:0] nb, input logic [255:0] d);
    link_ok = lk; in_valid = v; in_sof = s; in_eof = e; in_nbytes = nb; in_data = d;
    check("in_ready", {255'd0, in_ready}, {255'd0, m_ready()});
    m_step(lk, v, s, e, nb, d);
  endtask

  task automatic drive(input bit lk, v, s, e, input logic [5:0] nb, input logic [255:0] d);
    @(negedge clk);
    drive_now(lk, v, s, e, nb, d);
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom();
    return w;
  endfunction

  // Holds the word on the bus until the model says it is taken; bounded retries.
  task automatic send_word(input bit s, e, input logic [5:0] nb);
    logic [255:0] d;
    bit r;
    int k;
    d = rand_word();
    k = 0;
    do begin
      r = m_ready();
      drive(1, 1, s, e, nb, d);
      k++;
    end while (!r && k < 8);
    if (!r) check("send_word_timeout", {255'd0, r}, 256'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 6'd0, '0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        if (tx_data !== e.d || tx_ctrl !== e.c || frame_done !== e.fd ||
            underrun_err !== e.ue || proto_err !== e.pe) begin
          bad++;
          $display("FAIL out got=%h/%h fd%b ue%b pe%b want=%h/%h fd%b ue%b pe%b",
                   tx_data, tx_ctrl, frame_done, underrun_err, proto_err,
                   e.d, e.c, e.fd, e.ue, e.pe);
        end
      end
    end
  end

  initial begin
    int left, plen, down;
    bit lk, v, s, e, r;
    logic [5:0] nb;

    reset = 1; link_ok = 0; in_valid = 0; in_sof = 0; in_eof = 0;
    in_nbytes = '0; in_data = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", tx_data, IDLE_W);
    check("rst_ctrl", {224'd0, tx_ctrl}, {224'd0, 32'hFFFFFFFF});
    check("rst_pulses", {253'd0, frame_done, underrun_err, proto_err}, 256'd0);
    check("rst_ready", {255'd0, in_ready}, 256'd0);

    // Link down at release: remote fault, then idle once link comes up.
    @(negedge clk);
    reset = 0;
    drive_now(0, 0, 0, 0, 6'd0, '0);
    drive(0, 0, 0, 0, 6'd0, '0);
    idle(2);

    // 64-byte frames back to back, then 60-byte frame.
    send_word(1, 0, 6'd0); send_word(0, 1, 6'd32);
    send_word(1, 0, 6'd0); send_word(0, 1, 6'd32);
    send_word(1, 0, 6'd0); send_word(0, 1, 6'd28);
    idle(2);
    // Short eofs: IPG word needed for n=20, none for n=8.
    send_word(1, 0, 6'd0); send_word(0, 1, 6'd20);
    send_word(1, 0, 6'd0); send_word(0, 1, 6'd8);
    idle(1);
    // Single-word frames and nbytes edge values.
    send_word(1, 1, 6'd5);  idle(1);
    send_word(1, 1, 6'd0);  idle(1);
    send_word(1, 1, 6'd45); idle(1);
    send_word(1, 0, 6'd0); send_word(0, 1, 6'd23);
    send_word(1, 0, 6'd0); send_word(0, 1, 6'd24);
    send_word(1, 0, 6'd0); send_word(0, 1, 6'd1);
    idle(2);
    // Underrun mid-frame, then discard through eof.
    send_word(1, 0, 6'd0);
    idle(1);
    send_word(0, 0, 6'd0); send_word(0, 1, 6'd10);
    idle(2);
    // Non-sof word in IDLE.
    drive(1, 1, 0, 0, 6'd5, rand_word());
    idle(1);
    // Link loss mid-frame.
    send_word(1, 0, 6'd0);
    drive(0, 1, 0, 0, 6'd0, rand_word());
    drive(0, 0, 0, 0, 6'd0, '0);
    idle(3);

    // Randomized traffic with occasional stalls, garbage words and link drops.
    left = 0; down = 0;
    for (int c = 0; c < 3000; c++) begin
      lk = 1; s = 0; e = 0; v = 0; plen = 0;
      nb = 6'($urandom_range(0, 63));
      if (down > 0) begin lk = 0; down--; end
      else if ($urandom_range(0, 99) == 0) begin lk = 0; down = $urandom_range(0, 4); end
      if (left == 0) begin
        v = ($urandom_range(0, 3) != 0);
        if (v && $urandom_range(0, 9) != 0) begin
          s = 1;
          plen = $urandom_range(1, 4);
          e = (plen == 1);
        end else begin
          e = $urandom_range(0, 1) == 1;
        end
      end else begin
        v = ($urandom_range(0, 29) != 0);
        e = (left == 1);
      end
      r = m_ready();
      drive(lk, v, s, e, nb, rand_word());
      if (r && v) begin
        if (s) left = plen - 1;
        else if (left > 0) left--;
      end
    end

    // Asynchronous reset in the middle of a frame.
    for (int k = 0; k < 12 && !m_ready(); k++) drive(1, 0, 0, 0, 6'd0, '0);
    idle(3);
    send_word(1, 0, 6'd0);
    @(posedge clk);
    #2;
    @(negedge clk);
    reset = 1; in_valid = 0;
    #1;
    check("rstmid_data", tx_data, IDLE_W);
    check("rstmid_ctrl", {224'd0, tx_ctrl}, {224'd0, 32'hFFFFFFFF});
    m_reset();
    exp_q.delete();
    @(negedge clk);
    reset = 0;
    drive_now(1, 0, 0, 0, 6'd0, '0);
    idle(2);
    send_word(1, 0, 6'd0); send_word(0, 1, 6'd16);
    idle(4);

    repeat (2) @(posedge clk);
    #3;
    check("drain", 256'(exp_q.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
